smm_result_monitor: RTL and testbench

- Parametrised board-level controller placed between the raw board buttons/switches, the SMM1 Strassen multiplier and the LED bank.
- Debounces the start button and issues a single-cycle load pulse to the multiplier.
- Waits for the multiplier's result-valid handshake, with a timeout, then captures the result matrix.
- Drives the LEDs in one of four display modes. The threshold is runtime-programmable.

---
 rtl/smm_board_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 49 ++++
 rtl/smm_result_monitor.sv | 172 +++++++++++++++++
 tb/tb_smm_result_monitor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/smm_board_pkg.sv
// Shared types and constants for the SMM1 board controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package smm_board_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  // LED display mode encodings.
  localparam logic [1:0] MODE_THRESH = 2'b00;
  localparam logic [1:0] MODE_LO     = 2'b01;
  localparam logic [1:0] MODE_HI     = 2'b10;
  localparam logic [1:0] MODE_STATUS = 2'b11;

  // Default result geometry of the SMM1 multiplier.
  localparam int DEFAULT_DATAWIDTH = 32;
  localparam int DEFAULT_NUM_ELEM  = 16;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-level debounce, rising-edge detect.
// Latency: level follows btn_raw 2 + DEBOUNCE_CYCLES cycles after it settles; rise_pulse 1 cycle after.
// Backpressure: none; rise_pulse is a one-cycle event that the consumer must take or lose.
// Ports: clk, rst_n (sync, active-low), btn_raw (async input), level (debounced), rise_pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_1  <= btn_raw;
      sync_2  <= sync_1;
      level_d <= level;
      // Count consecutive samples that disagree with the accepted level;
      // any agreeing sample (a bounce back) restarts the count.
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync_2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise_pulse = level & ~level_d;

endmodule

// File: rtl/smm_result_monitor.sv
// Board controller: debounced start -> load pulse -> wait for c_valid (with timeout) -> capture -> LEDs.
// Latency: load/busy 1 cycle after the debounced rise; led registered, 1 cycle after any input change.
// Backpressure: none; starts outside IDLE are dropped and c_valid outside WAIT is ignored.
// Ports: clk, rst_n (sync, active-low), btn_start, mode, elem_idx, thr_load, thr_value,
//        C_in, c_valid (inputs); load, busy, timeout, result_valid, led (outputs).
module smm_result_monitor
  import smm_board_pkg::*;
#(
  parameter int          DATAWIDTH         = DEFAULT_DATAWIDTH,
  parameter int          NUM_ELEM          = DEFAULT_NUM_ELEM,
  parameter int          LED_WIDTH         = 16,
  parameter int          DEBOUNCE_CYCLES   = 1000000,
  parameter int          TIMEOUT_CYCLES    = 64,
  parameter int unsigned THRESHOLD_DEFAULT = 250
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          btn_start,
  input  logic [1:0]                    mode,
  input  logic [$clog2(NUM_ELEM)-1:0]   elem_idx,
  input  logic                          thr_load,
  input  logic [DATAWIDTH-1:0]          thr_value,
  input  logic [DATAWIDTH*NUM_ELEM-1:0] C_in,
  input  logic                          c_valid,
  output logic                          load,
  output logic                          busy,
  output logic                          timeout,
  output logic                          result_valid,
  output logic [LED_WIDTH-1:0]          led
);

  localparam int IW   = $clog2(NUM_ELEM);
  localparam int NSEL = 2 ** IW;
  localparam int NTHR = (NUM_ELEM < LED_WIDTH) ? NUM_ELEM : LED_WIDTH;
  localparam int WCW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);

  logic                          start_req;
  logic                          btn_level;
  state_t                        state;
  state_t                        state_nxt;
  logic [WCW-1:0]                wait_cnt;
  logic [DATAWIDTH*NUM_ELEM-1:0] result_q;
  logic [DATAWIDTH-1:0]          thr_q;
  logic [DATAWIDTH-1:0]          elem_tab [NSEL];
  logic [DATAWIDTH-1:0]          elem_sel;
  logic [LED_WIDTH-1:0]          sel_lo;
  logic [LED_WIDTH-1:0]          sel_hi;
  logic [LED_WIDTH-1:0]          led_nxt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_start),
    .level     (btn_level),
    .rise_pulse(start_req)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  // c_valid is checked before the timeout so a result arriving on the
  // final wait cycle is still captured.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_req) state_nxt = LOAD;
      LOAD:    state_nxt = WAIT;
      WAIT:    if (c_valid || (wait_cnt == WAIT_LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    load = (state == LOAD);
    busy = (state == LOAD) || (state == WAIT);
  end

  // ---------------- Run datapath ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt     <= '0;
      timeout      <= 1'b0;
      result_valid <= 1'b0;
      result_q     <= '0;
    end else begin
      case (state)
        IDLE: if (start_req) timeout <= 1'b0;
        LOAD: wait_cnt <= '0;
        WAIT: begin
          if (c_valid) begin
            result_q     <= C_in;
            result_valid <= 1'b1;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- Threshold register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      thr_q <= DATAWIDTH'(THRESHOLD_DEFAULT);
    end else if (thr_load) begin
      thr_q <= thr_value;
    end
  end

  // ---------------- Element selection ----------------
  // Table padded to a power of two so any elem_idx value is a legal index;
  // the padding entries read as zero.
  for (genvar g = 0; g < NSEL; g++) begin : g_tab
    if (g < NUM_ELEM) begin : g_real
      assign elem_tab[g] = result_q[g*DATAWIDTH +: DATAWIDTH];
    end else begin : g_pad
      assign elem_tab[g] = '0;
    end
  end

  assign elem_sel = elem_tab[elem_idx];

  if (DATAWIDTH >= LED_WIDTH) begin : g_wide
    assign sel_lo = elem_sel[LED_WIDTH-1:0];
    assign sel_hi = elem_sel[DATAWIDTH-1 -: LED_WIDTH];
  end else begin : g_narrow
    assign sel_lo = LED_WIDTH'(elem_sel);
    assign sel_hi = LED_WIDTH'(elem_sel);
  end

  // ---------------- LED drive ----------------
  always_comb begin
    led_nxt = '0;
    case (mode)
      MODE_THRESH: begin
        for (int i = 0; i < NTHR; i++) begin
          led_nxt[i] = (result_q[i*DATAWIDTH +: DATAWIDTH] > thr_q);
        end
      end
      MODE_LO: led_nxt = sel_lo;
      MODE_HI: led_nxt = sel_hi;
      default: begin
        led_nxt[0] = busy;
        led_nxt[1] = timeout;
        led_nxt[2] = result_valid;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      led <= led_nxt;
    end
  end

endmodule

// File: tb/tb_smm_result_monitor.sv
module tb_smm_result_monitor;

  localparam int DW  = 32;
  localparam int NE  = 16;
  localparam int LW  = 16;
  localparam int DEB = 4;
  localparam int TO  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             btn_start;
  logic [1:0]       mode;
  logic [3:0]       elem_idx;
  logic             thr_load;
  logic [DW-1:0]    thr_value;
  logic [DW*NE-1:0] C_in;
  logic             c_valid;
  logic             load;
  logic             busy;
  logic             timeout;
  logic             result_valid;
  logic [LW-1:0]    led;

  smm_result_monitor #(
    .DATAWIDTH        (DW),
    .NUM_ELEM         (NE),
    .LED_WIDTH        (LW),
    .DEBOUNCE_CYCLES  (DEB),
    .TIMEOUT_CYCLES   (TO),
    .THRESHOLD_DEFAULT(250)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_start   (btn_start),
    .mode        (mode),
    .elem_idx    (elem_idx),
    .thr_load    (thr_load),
    .thr_value   (thr_value),
    .C_in        (C_in),
    .c_valid     (c_valid),
    .load        (load),
    .busy        (busy),
    .timeout     (timeout),
    .result_valid(result_valid),
    .led         (led)
  );

  int total = 0;
  int bad   = 0;

  // Cycle counters for pulses, sampled mid-cycle.
  int load_cnt = 0;
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (load === 1'b1) load_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end

  // Reference model state.
  logic [DW-1:0] m_res [NE];
  logic [DW-1:0] m_thr;
  bit            m_rv;
  bit            m_to;
  logic [DW-1:0] stim  [NE];

  typedef struct {
    bit          wr;
    logic [31:0] thr;
    logic [1:0]  md;
    logic [3:0]  idx;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_led(input logic [1:0] md, input int idx, input bit bsy);
    logic [15:0] r;
    r = '0;
    case (md)
      2'b00: for (int i = 0; i < 16; i++) r[i] = (m_res[i] > m_thr);
      2'b01: r = m_res[idx][15:0];
      2'b10: r = m_res[idx][31:16];
      default: r = {13'd0, m_rv, m_to, bsy};
    endcase
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NE; k++) m_res[k] = '0;
    m_thr = 32'd250;
    m_rv  = 1'b0;
    m_to  = 1'b0;
  endtask

  task automatic pack_cin();
    for (int k = 0; k < NE; k++) C_in[k*DW +: DW] = stim[k];
  endtask

  task automatic ramp_stim();
    for (int k = 0; k < NE; k++) stim[k] = 32'(k * 20);
  endtask

  // Press the button, wait for load, pulse c_valid d cycles after the load
  // cycle, then let everything settle. Captured iff c_valid lands in one
  // of the TO wait cycles that follow the load cycle.
  task automatic do_run(input int d, input bit bounce);
    int l0, b0, n;
    bit cap;
    l0 = load_cnt;
    b0 = busy_cnt;
    pack_cin();
    if (bounce) begin
      btn_start = 1'b1; tick();
      btn_start = 1'b0; tick();
    end
    btn_start = 1'b1;
    n = 0;
    while (load !== 1'b1 && n < 40) begin tick(); n++; end
    if (load !== 1'b1) begin
      total++; bad++;
      $display("FAIL run_start: load=%b after %0d cycles, expected a pulse", load, n);
      btn_start = 1'b0;
      return;
    end
    btn_start = 1'b0;
    repeat (d) tick();
    c_valid = 1'b1; tick(); c_valid = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin tick(); n++; end
    check("run_idle", 32'(busy), 32'd0);
    repeat (10) tick();
    cap = (d >= 1 && d <= TO);
    if (cap) begin
      for (int k = 0; k < NE; k++) m_res[k] = stim[k];
      m_rv = 1'b1;
      m_to = 1'b0;
    end else begin
      m_to = 1'b1;
    end
    check("run_loads", 32'(load_cnt - l0), 32'd1);
    check("run_busy_cycles", 32'(busy_cnt - b0), cap ? 32'(d + 1) : 32'(TO + 1));
    check("run_timeout", 32'(timeout), 32'(m_to));
    check("run_result_valid", 32'(result_valid), 32'(m_rv));
  endtask

  initial begin
    int l0, b0, n;
    rst_n = 1'b0; btn_start = 1'b0; mode = 2'd0; elem_idx = '0;
    thr_load = 1'b0; thr_value = '0; C_in = '0; c_valid = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_load", 32'(load), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Bounced press, c_valid 3 cycles after load, ramp data.
    ramp_stim();
    do_run(3, 1'b1);
    check("ramp_led_thr250", 32'(led), 32'h0000_E000);

    // Threshold write: visible on led one cycle after the write edge.
    thr_load = 1'b1; thr_value = 32'd100; tick();
    thr_load = 1'b0; m_thr = 32'd100;
    check("thr_not_yet", 32'(led), 32'h0000_E000);
    tick();
    check("thr_led_100", 32'(led), 32'h0000_FFC0);

    // Timeout run with a second press landing during WAIT.
    l0 = load_cnt; b0 = busy_cnt;
    for (int i = 0; i < 12; i++) begin
      btn_start = (i < 4 || i >= 8);
      tick();
    end
    btn_start = 1'b0;
    repeat (20) tick();
    m_to = 1'b1;
    check("dbl_loads", 32'(load_cnt - l0), 32'd1);
    check("to_busy_cycles", 32'(busy_cnt - b0), 32'(TO + 1));
    check("to_timeout", 32'(timeout), 32'd1);
    check("to_result_valid_kept", 32'(result_valid), 32'd1);
    mode = 2'b11; tick(); tick();
    check("to_status_led", 32'(led), 32'h0000_0006);
    mode = 2'b00; tick(); tick();
    check("to_result_kept", 32'(led), 32'(model_led(2'b00, 0, 1'b0)));

    // c_valid on the final wait cycle: capture wins.
    ramp_stim();
    stim[5] = 32'hABCD_1234;
    do_run(TO, 1'b0);

    tbl[0]  = '{1'b1, 32'd100,        2'd0, 4'd0,  16'hFFE0};
    tbl[1]  = '{1'b1, 32'd250,        2'd0, 4'd0,  16'hE020};
    tbl[2]  = '{1'b1, 32'hFFFF_FFFF,  2'd0, 4'd0,  16'h0000};
    tbl[3]  = '{1'b1, 32'd0,          2'd0, 4'd0,  16'hFFFE};
    tbl[4]  = '{1'b0, 32'd0,          2'd1, 4'd5,  16'h1234};
    tbl[5]  = '{1'b0, 32'd0,          2'd2, 4'd5,  16'hABCD};
    tbl[6]  = '{1'b0, 32'd0,          2'd1, 4'd0,  16'h0000};
    tbl[7]  = '{1'b0, 32'd0,          2'd1, 4'd15, 16'h012C};
    tbl[8]  = '{1'b0, 32'd0,          2'd2, 4'd15, 16'h0000};
    tbl[9]  = '{1'b0, 32'd0,          2'd3, 4'd0,  16'h0004};
    tbl[10] = '{1'b1, 32'd250,        2'd0, 4'd0,  16'hE020};
    for (int i = 0; i < 11; i++) begin
      thr_load = tbl[i].wr; thr_value = tbl[i].thr;
      mode = tbl[i].md; elem_idx = tbl[i].idx;
      tick();
      thr_load = 1'b0;
      if (tbl[i].wr) m_thr = tbl[i].thr;
      tick();
      check($sformatf("table_%0d", i), 32'(led), 32'(tbl[i].exp));
    end

    // Reset in the middle of WAIT.
    mode = 2'b11;
    btn_start = 1'b1;
    n = 0;
    while (load !== 1'b1 && n < 40) begin tick(); n++; end
    check("rstmid_load_seen", 32'(load), 32'd1);
    btn_start = 1'b0;
    tick(); tick();
    rst_n = 1'b0; tick();
    check("rstmid_load", 32'(load), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_timeout", 32'(timeout), 32'd0);
    check("rstmid_result_valid", 32'(result_valid), 32'd0);
    check("rstmid_led", 32'(led), 32'd0);
    rst_n = 1'b1;
    model_reset();
    l0 = load_cnt;
    repeat (20) tick();
    check("rstmid_no_load", 32'(load_cnt - l0), 32'd0);
    check("rstmid_idle_led", 32'(led), 32'd0);
    mode = 2'b00;
    ramp_stim();
    do_run(2, 1'b0);
    check("rstmid_thr_default", 32'(led), 32'h0000_E000);

    // Randomized runs against the model.
    for (int it = 0; it < 24; it++) begin
      int d;
      for (int k = 0; k < NE; k++)
        stim[k] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 500)) : 32'($urandom);
      d = $urandom_range(0, 10);
      do_run(d, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        thr_load = 1'b1;
        thr_value = 32'($urandom_range(0, 500));
      end
      mode = 2'($urandom_range(0, 3));
      elem_idx = 4'($urandom_range(0, 15));
      tick();
      if (thr_load) m_thr = thr_value;
      thr_load = 1'b0;
      tick();
      check($sformatf("rand_led_%0d", it), 32'(led), 32'(model_led(mode, int'(elem_idx), 1'b0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
